// File: rtl/gcn_layer_scheduler_if.sv
// Handshake bundle between the GCN layer scheduler and its environment:
// run control in, engine done levels in, engine reset/start and status out.
interface gcn_layer_scheduler_if #(
    parameter int NUM_LAYERS = 2,
    parameter int LAYER_W    = ($clog2(NUM_LAYERS) > 0) ? $clog2(NUM_LAYERS) : 1
);
    logic               start;
    logic               abort;
    logic               trans_done;
    logic               agg_done;
    logic               trans_reset;
    logic               trans_start;
    logic               agg_reset;
    logic               agg_start;
    logic [LAYER_W-1:0] layer_idx;
    logic               busy;
    logic               done;
    logic               error;

    // Environment side: issues run control and reports engine completion.
    modport master (
        output start, abort, trans_done, agg_done,
        input  trans_reset, trans_start, agg_reset, agg_start,
        input  layer_idx, busy, done, error
    );

    // Scheduler side.
    modport slave (
        input  start, abort, trans_done, agg_done,
        output trans_reset, trans_start, agg_reset, agg_start,
        output layer_idx, busy, done, error
    );
endinterface

// File: rtl/gcn_layer_scheduler.sv
// GCN layer phase sequencer. For each layer: reset+start the transformation
// engine, wait for its done, then reset+start the aggregation engine and wait.
// After NUM_LAYERS layers it parks in DONE. Each wait phase has a watchdog
// that sends the FSM to ERROR; abort returns to IDLE from anywhere.
module gcn_layer_scheduler #(
    parameter int NUM_LAYERS     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LAYER_W        = ($clog2(NUM_LAYERS) > 0) ? $clog2(NUM_LAYERS) : 1,
    parameter int TO_W           = ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    gcn_layer_scheduler_if.slave   bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T_RST,
        S_T_START,
        S_T_WAIT,
        S_A_RST,
        S_A_START,
        S_A_WAIT,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [TO_W-1:0]    WDOG_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam bit                 WDOG_EN    = (TIMEOUT_CYCLES != 0);

    state_t             state;
    state_t             nxt;
    logic [LAYER_W-1:0] layer_idx;
    logic [TO_W-1:0]    wdog;
    logic               wdog_hit;

    logic trans_reset_q, trans_start_q, agg_reset_q, agg_start_q;
    logic busy_q, done_q, error_q;

    // Watchdog expiry on the last allowed WAIT cycle; the caller still lets
    // a same-cycle done take priority.
    assign wdog_hit = WDOG_EN && (wdog == WDOG_LAST);

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (bus.start) nxt = S_T_RST;
            S_T_RST:   nxt = S_T_START;
            S_T_START: nxt = S_T_WAIT;
            S_T_WAIT: begin
                if (bus.trans_done)  nxt = S_A_RST;
                else if (wdog_hit)   nxt = S_ERROR;
            end
            S_A_RST:   nxt = S_A_START;
            S_A_START: nxt = S_A_WAIT;
            S_A_WAIT: begin
                if (bus.agg_done)    nxt = (layer_idx == LAST_LAYER) ? S_DONE : S_NEXT;
                else if (wdog_hit)   nxt = S_ERROR;
            end
            S_NEXT:    nxt = S_T_RST;
            S_DONE:    if (bus.start) nxt = S_T_RST;
            S_ERROR:   if (bus.start) nxt = S_T_RST;
            default:   nxt = S_IDLE;
        endcase
        if (bus.abort && state != S_IDLE) nxt = S_IDLE;
    end

    // State, layer counter, watchdog and Moore outputs registered from the
    // next state so every output is a flop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            layer_idx     <= '0;
            wdog          <= '0;
            trans_reset_q <= 1'b1;
            trans_start_q <= 1'b0;
            agg_reset_q   <= 1'b1;
            agg_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state <= nxt;

            // Layer index: cleared on abort and on a fresh run, bumped only
            // when NEXT hands over to the following layer.
            if (nxt == S_IDLE ||
                ((state == S_DONE || state == S_ERROR) && nxt == S_T_RST))
                layer_idx <= '0;
            else if (state == S_NEXT && nxt == S_T_RST)
                layer_idx <= layer_idx + LAYER_W'(1);

            // Watchdog: zeroed by each start, counts idle WAIT cycles, saturates.
            if (state == S_T_START || state == S_A_START)
                wdog <= '0;
            else if ((state == S_T_WAIT && !bus.trans_done) ||
                     (state == S_A_WAIT && !bus.agg_done)) begin
                if (wdog != '1) wdog <= wdog + TO_W'(1);
            end

            trans_reset_q <= 1'b0;
            trans_start_q <= 1'b0;
            agg_reset_q   <= 1'b0;
            agg_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            case (nxt)
                S_IDLE:    begin trans_reset_q <= 1'b1; agg_reset_q <= 1'b1; end
                S_T_RST:   begin trans_reset_q <= 1'b1; busy_q <= 1'b1; end
                S_T_START: begin trans_start_q <= 1'b1; busy_q <= 1'b1; end
                S_T_WAIT:  busy_q <= 1'b1;
                S_A_RST:   begin agg_reset_q <= 1'b1; busy_q <= 1'b1; end
                S_A_START: begin agg_start_q <= 1'b1; busy_q <= 1'b1; end
                S_A_WAIT:  busy_q <= 1'b1;
                S_NEXT:    busy_q <= 1'b1;
                S_DONE:    done_q <= 1'b1;
                S_ERROR:   error_q <= 1'b1;
                default:   begin trans_reset_q <= 1'b1; agg_reset_q <= 1'b1; end
            endcase
        end
    end

    assign bus.trans_reset = trans_reset_q;
    assign bus.trans_start = trans_start_q;
    assign bus.agg_reset   = agg_reset_q;
    assign bus.agg_start   = agg_start_q;
    assign bus.layer_idx   = layer_idx;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;

endmodule
